// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 core and its bring-up loader:
// loader phase encoding, opcode field values and the halt instruction word.
package mips32_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REG_INIT = 3'd1,
    S_LOAD     = 3'd2,
    S_RUN      = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_ADDI = 6'h04;
  localparam logic [5:0] OP_LW   = 6'h06;
  localparam logic [5:0] OP_SW   = 6'h07;
  localparam logic [5:0] OP_BR   = 6'h08;

  // Opcode 6'h3F is unused by the core, so this word can never be a real instruction.
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

endpackage

// File: rtl/mips32_run_monitor.sv
// RUN-phase supervisor: cycle and retire counters plus the halt / timeout
// compares that tell the loader when to stop the core.
module mips32_run_monitor #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              run,
  input  logic [DATA_W-1:0] core_pc,
  input  logic [DATA_W-1:0] wb_out,
  input  logic [DATA_W-1:0] halt_pc,
  input  logic [CNT_W-1:0]  max_cycles,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count,
  output logic              halt_hit,
  output logic              timeout_hit
);

  logic [DATA_W-1:0] wb_prev_reg;
  logic              sampled_reg;
  logic [CNT_W-1:0]  cycle_next;

  // The timeout compares against the count this cycle will produce, so a
  // run stopped by timeout reports exactly max_cycles.
  always_comb begin
    cycle_next  = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
    halt_hit    = run && (core_pc == halt_pc);
    timeout_hit = run && (max_cycles != '0) && (cycle_next == max_cycles);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count  <= '0;
      retire_count <= '0;
      wb_prev_reg  <= '0;
      sampled_reg  <= 1'b0;
    end else if (clear) begin
      cycle_count  <= '0;
      retire_count <= '0;
      wb_prev_reg  <= '0;
      sampled_reg  <= 1'b0;
    end else if (run) begin
      cycle_count <= cycle_next;
      wb_prev_reg <= wb_out;
      sampled_reg <= 1'b1;
      // The first RUN cycle only captures wb_out; nothing to compare against yet.
      if (sampled_reg && (wb_out != wb_prev_reg) && !(&retire_count))
        retire_count <= retire_count + CNT_W'(1);
    end else begin
      sampled_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/mips32_prog_loader.sv
// Bring-up sequencer for the mips32 core: seeds REG[k]=k, streams a program
// into instruction memory, then runs the core until halt PC or timeout.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int NUM_REGS  = 32,
  parameter int INIT_REGS = 1,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [ADDR_W-1:0]           ld_addr,
  input  logic [DATA_W-1:0]           ld_data,
  input  logic                        ld_last,
  input  logic [DATA_W-1:0]           halt_pc,
  input  logic [CNT_W-1:0]            max_cycles,
  input  logic [DATA_W-1:0]           core_pc,
  input  logic [DATA_W-1:0]           wb_out,
  output logic                        reg_we,
  output logic [$clog2(NUM_REGS)-1:0] reg_waddr,
  output logic [DATA_W-1:0]           reg_wdata,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_waddr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        core_run,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout,
  output logic [CNT_W-1:0]            cycle_count,
  output logic [CNT_W-1:0]            load_count,
  output logic [CNT_W-1:0]            retire_count
);

  localparam int              RA_W     = $clog2(NUM_REGS);
  localparam logic [RA_W-1:0] LAST_REG = RA_W'(NUM_REGS - 1);

  state_t state_reg;
  logic   last_pending_reg;
  logic   start_ok;
  logic   run_phase;
  logic   halt_hit;
  logic   timeout_hit;

  assign start_ok  = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign run_phase = (state_reg == S_RUN);

  mips32_run_monitor #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_run_monitor (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (start_ok),
    .run         (run_phase),
    .core_pc     (core_pc),
    .wb_out      (wb_out),
    .halt_pc     (halt_pc),
    .max_cycles  (max_cycles),
    .cycle_count (cycle_count),
    .retire_count(retire_count),
    .halt_hit    (halt_hit),
    .timeout_hit (timeout_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      last_pending_reg <= 1'b0;
      ld_ready         <= 1'b0;
      reg_we           <= 1'b0;
      reg_waddr        <= '0;
      reg_wdata        <= '0;
      mem_we           <= 1'b0;
      mem_waddr        <= '0;
      mem_wdata        <= '0;
      core_run         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      timeout          <= 1'b0;
      load_count       <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            done             <= 1'b0;
            timeout          <= 1'b0;
            load_count       <= '0;
            last_pending_reg <= 1'b0;
            busy             <= 1'b1;
            if (INIT_REGS != 0) begin
              state_reg <= S_REG_INIT;
              reg_we    <= 1'b1;
              reg_waddr <= '0;
              reg_wdata <= '0;
            end else begin
              state_reg <= S_LOAD;
              ld_ready  <= 1'b1;
            end
          end
        end
        S_REG_INIT: begin
          if (reg_waddr == LAST_REG) begin
            reg_we    <= 1'b0;
            state_reg <= S_LOAD;
            ld_ready  <= 1'b1;
          end else begin
            reg_waddr <= reg_waddr + RA_W'(1);
            reg_wdata <= DATA_W'(reg_waddr) + DATA_W'(1);
          end
        end
        S_LOAD: begin
          // After the last handshake, wait out its write cycle before releasing the core.
          if (last_pending_reg) begin
            last_pending_reg <= 1'b0;
            state_reg        <= S_RUN;
            core_run         <= 1'b1;
          end else if (ld_valid && ld_ready) begin
            mem_we    <= 1'b1;
            mem_waddr <= ld_addr;
            mem_wdata <= ld_data;
            if (!(&load_count))
              load_count <= load_count + CNT_W'(1);
            if (ld_last) begin
              ld_ready         <= 1'b0;
              last_pending_reg <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (halt_hit || timeout_hit) begin
            state_reg <= S_DONE;
            core_run  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            timeout   <= !halt_hit;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Randomised self-checking bench for mips32_prog_loader: each scenario seeds
// the register file, streams a program and supervises a modelled core run.
module tb_mips32_prog_loader;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 10;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic [DATA_W-1:0] halt_pc;
  logic [CNT_W-1:0]  max_cycles;
  logic [DATA_W-1:0] core_pc;
  logic [DATA_W-1:0] wb_out;
  logic              reg_we;
  logic [4:0]        reg_waddr;
  logic [DATA_W-1:0] reg_wdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              core_run;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  load_count;
  logic [CNT_W-1:0]  retire_count;

  mips32_prog_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .INIT_REGS(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .halt_pc(halt_pc), .max_cycles(max_cycles), .core_pc(core_pc), .wb_out(wb_out),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .core_run(core_run), .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .load_count(load_count), .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] ref_mem [1024];
  logic [DATA_W-1:0] dut_mem [1024];
  logic [ADDR_W-1:0] prog_addr [16];
  logic [DATA_W-1:0] prog_data [16];
  int                run_id = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ctl"}, {ld_ready, reg_we, mem_we, core_run, busy, done, timeout}, 64'd0);
    chk({tag, "_regw"}, {reg_waddr, reg_wdata}, 64'd0);
    chk({tag, "_memw"}, {mem_waddr, mem_wdata}, 64'd0);
    chk({tag, "_cnt"}, {cycle_count, load_count, retire_count}, 64'd0);
  endtask

  task automatic clear_models();
    for (int a = 0; a < 1024; a++) begin
      ref_mem[a] = '0;
      dut_mem[a] = '0;
    end
  endtask

  // Entered on a negedge in IDLE/DONE; leaves on the negedge where LOAD has begun.
  task automatic reg_init_phase();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clr_counts", {cycle_count, load_count, retire_count}, 64'd0);
    chk("clr_flags", {done, timeout}, 64'd0);
    for (int k = 0; k < NUM_REGS; k++) begin
      chk("reg_we", reg_we, 1);
      chk("reg_waddr", reg_waddr, k);
      chk("reg_wdata", reg_wdata, k);
      chk("init_ld_ready", ld_ready, 0);
      chk("init_mem_we", mem_we, 0);
      chk("init_busy", busy, 1);
      ld_valid = 1'($urandom_range(0, 1));
      ld_last  = 1'b1;
      ld_addr  = ADDR_W'($urandom);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("init_end_reg_we", reg_we, 0);
    chk("load_ld_ready", ld_ready, 1);
  endtask

  task automatic load_phase(input int n, input int abort_after, output bit aborted);
    bit                exp_we = 1'b0;
    bit                v;
    int                sent = 0;
    logic [ADDR_W-1:0] ea = '0;
    logic [DATA_W-1:0] ed = '0;
    aborted = 1'b0;
    for (int guard = 0; guard < 500; guard++) begin
      chk("mem_we", mem_we, exp_we);
      if (mem_we) dut_mem[mem_waddr] = mem_wdata;
      if (exp_we) begin
        chk("mem_waddr", mem_waddr, ea);
        chk("mem_wdata", mem_wdata, ed);
      end
      chk("load_reg_we", reg_we, 0);
      chk("ld_ready", ld_ready, (sent < n));
      if (exp_we && sent == n) break;
      if (abort_after > 0 && sent == abort_after) begin
        rst_n    = 1'b0;
        start    = 1'b0;
        ld_valid = 1'b1;
        #1;
        all_zero("rst_mid");
        repeat (2) @(negedge clk);
        all_zero("rst_hold");
        ld_valid = 1'b0;
        rst_n    = 1'b1;
        aborted  = 1'b1;
        return;
      end
      v        = ($urandom_range(0, 3) != 0);
      ld_valid = v;
      ld_addr  = prog_addr[sent];
      ld_data  = prog_data[sent];
      ld_last  = (sent == n - 1);
      start    = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      exp_we = v;
      if (v) begin
        ea = prog_addr[sent];
        ed = prog_data[sent];
        ref_mem[ea] = ed;
        sent++;
      end
    end
    // A word offered while ld_ready is low must not be written.
    start    = 1'b0;
    ld_valid = 1'b1;
    ld_last  = 1'b0;
    ld_addr  = ADDR_W'($urandom);
    ld_data  = $urandom;
    @(negedge clk);
    ld_valid = 1'b0;
    chk("run_core_run", core_run, 1);
    chk("run_ld_ready0", ld_ready, 0);
    chk("stall_mem_we", mem_we, 0);
    chk("load_count", load_count, n);
    chk("run_busy", busy, 1);
  endtask

  task automatic run_phase(input int h, input int maxc, input logic [DATA_W-1:0] hpc, input int n);
    int                i = 1;
    int                retire_exp = 0;
    int                exp_n;
    bit                exp_to;
    logic [DATA_W-1:0] wprev;
    logic [DATA_W-1:0] wb;
    wprev = wb_out;
    while (core_run === 1'b1 && i <= 400) begin
      chk("cycle_count", cycle_count, i - 1);
      chk("run_mem_we", mem_we, 0);
      chk("run_ld_rdy", ld_ready, 0);
      core_pc = (i == h) ? hpc : (hpc ^ (32'h1 << $urandom_range(0, 31)));
      wb = $urandom_range(0, 1) ? wprev : $urandom;
      if (i > 1 && wb != wprev) retire_exp++;
      wprev    = wb;
      wb_out   = wb;
      ld_valid = 1'($urandom_range(0, 1));
      start    = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      i++;
    end
    start    = 1'b0;
    ld_valid = 1'b0;
    if (h != 0 && (maxc == 0 || h <= maxc)) begin
      exp_n  = h;
      exp_to = 1'b0;
    end else begin
      exp_n  = maxc;
      exp_to = 1'b1;
    end
    chk("run_length", i - 1, exp_n);
    chk("final_cycles", cycle_count, exp_n);
    chk("final_retire", retire_count, retire_exp);
    chk("final_done", done, 1);
    chk("final_timeout", timeout, exp_to);
    chk("final_core_run", core_run, 0);
    chk("final_busy", busy, 0);
    $display("run %0d: words=%0d halt_cycle=%0d max=%0d cycles=%0d retires=%0d timeout=%0b",
             run_id, n, h, maxc, cycle_count, retire_count, timeout);
    repeat (3) begin
      core_pc = hpc;
      wb_out  = $urandom;
      @(negedge clk);
    end
    chk("hold_done", {done, timeout}, {exp_to ? 2'b11 : 2'b10});
    chk("hold_counts", {cycle_count, retire_count, load_count}, {CNT_W'(exp_n), CNT_W'(retire_exp), CNT_W'(n)});
  endtask

  task automatic scenario(input int n, input bit directed, input int h, input int maxc,
                          input logic [DATA_W-1:0] hpc, input int abort_after);
    bit ab;
    int diffs = 0;
    logic [DATA_W-1:0] dir_words [6];
    dir_words = '{32'h00222000, 32'h04432800, 32'h10E60001, 32'h1D090001, 32'h190A0001, 32'h20000028};
    run_id++;
    for (int w = 0; w < n; w++) begin
      if (directed) begin
        prog_addr[w] = ADDR_W'(w);
        prog_data[w] = dir_words[w];
      end else begin
        prog_addr[w] = $urandom_range(0, 1) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
        prog_data[w] = $urandom;
      end
    end
    clear_models();
    halt_pc    = hpc;
    max_cycles = CNT_W'(maxc);
    core_pc    = '0;
    wb_out     = $urandom;
    reg_init_phase();
    load_phase(n, abort_after, ab);
    if (ab) begin
      @(negedge clk);
      all_zero("post_rst");
      clear_models();
      reg_init_phase();
      load_phase(n, 0, ab);
    end
    for (int a = 0; a < 1024; a++)
      if (dut_mem[a] !== ref_mem[a]) diffs++;
    chk("mem_image_diffs", diffs, 0);
    run_phase(h, maxc, hpc, n);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    halt_pc = '0; max_cycles = '0; core_pc = '0; wb_out = '0;
    repeat (3) @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;

    scenario(6, 1'b1, 9, 0, 32'd47, 0);
    scenario(6, 1'b1, 0, 20, 32'd47, 0);
    scenario(6, 1'b1, 15, 15, 32'd47, 0);
    scenario(6, 1'b0, 12, 0, $urandom, 3);
    for (int r = 0; r < 8; r++) begin
      int h;
      int m;
      h = $urandom_range(0, 30);
      m = $urandom_range(0, 30);
      if (h == 0 && m == 0) m = 20;
      scenario($urandom_range(1, 10), 1'b0, h, m, $urandom, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mips32_prog_loader.md
Name: mips32_prog_loader

Overview:
- Parametrised bring-up controller for the mips32_RISCV core. It replaces ad-hoc hierarchical preloading of REG/MEM and PC with a synthesizable sequence.
- Sequence: initialise the register file (REG[k]=k), stream a program into instruction memory over a valid/ready port, release the core, then supervise the run until a halt PC or a cycle timeout.
- Sits between a host/bench stream source and the core's register-file write port, memory write port and run/hold input.

Parameters:
- DATA_W, 32, data/instruction/PC width.
- ADDR_W, 10, instruction-memory word-address width (depth 2**ADDR_W).
- NUM_REGS, 32, register count; reg address width RA_W = clog2(NUM_REGS).
- INIT_REGS, 1, 1 = run the REG_INIT phase; 0 = skip it.
- CNT_W, 16, width of the cycle and retire counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin sequence; honoured only in IDLE or DONE.
- ld_valid  in  1  program word valid.
- ld_ready  out  1  loader accepting words.
- ld_addr  in  ADDR_W  target word address.
- ld_data  in  DATA_W  instruction word.
- ld_last  in  1  final word of program.
- halt_pc  in  DATA_W  PC value that ends the run.
- max_cycles  in  CNT_W  run timeout; 0 disables the timeout.
- core_pc  in  DATA_W  core PC.
- wb_out  in  DATA_W  core write-back bus.
- reg_we  out  1  register-file write enable.
- reg_waddr  out  RA_W  register address.
- reg_wdata  out  DATA_W  register data.
- mem_we  out  1  instruction-memory write enable.
- mem_waddr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory data.
- core_run  out  1  1 = core clocks normally; 0 = core held with PC forced to 0.
- busy  out  1  state is neither IDLE nor DONE.
- done  out  1  run finished.
- timeout  out  1  run finished by timeout.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- load_count  out  CNT_W  words accepted.
- retire_count  out  CNT_W  wb_out changes seen during RUN.

Behaviour:
- States: IDLE, REG_INIT, LOAD, RUN, DONE. All outputs are registered.
- Async reset: state=IDLE; every output and counter = 0. Reset mid-phase aborts the phase; already written REG/MEM contents are left as they are.
- IDLE/DONE + start:
  - clear done, timeout and all counters;
  - go to REG_INIT if INIT_REGS, else LOAD.
  - start is ignored in every other state.
- REG_INIT: one write per cycle for NUM_REGS cycles, k=0..NUM_REGS-1:
  - reg_we=1, reg_waddr=k, reg_wdata=k zero-extended;
  - after k=NUM_REGS-1, reg_we=0 and go to LOAD.
- LOAD:
  - ld_ready=1 for the whole state;
  - on each valid&ready: mem_we=1, mem_waddr=ld_addr, mem_wdata=ld_data on the next cycle (1-cycle latency), and load_count+1 (saturating);
  - a handshake with ld_last: ld_ready drops the following cycle, state goes to RUN one cycle after the last mem_we;
  - duplicate addresses are allowed, and the last write wins;
  - ld_valid while ld_ready=0 is ignored.
- RUN:
  - core_run=1; cycle_count+1 each cycle, saturating at all-ones;
  - a change in wb_out versus its last registered value gives retire_count+1 (saturating); the first RUN cycle only samples and does not count;
  - core_pc==halt_pc → DONE, done=1, timeout=0;
  - max_cycles≠0 and cycle_count==max_cycles → DONE, done=1, timeout=1;
  - both in the same cycle → halt wins (timeout=0).
- DONE:
  - core_run=0;
  - done, timeout and counters hold until start or reset.
- Width rules: halt_pc compare is full DATA_W; load address wraps naturally within ADDR_W.

Decomposition:
- Package mips32_pkg holds:
  - state enum/localparams (IDLE=0 … DONE=4);
  - opcode constants shared with the core (ADD=6'h00, SUB=6'h01, ADDI=6'h04, LW=6'h06, SW=6'h07, BR=6'h08);
  - HALT_WORD constant.
- Natural sub-module: mips32_run_monitor, which holds the RUN-phase cycle/retire counters and the halt/timeout compare.

Test Plan:
- Reset, then start with INIT_REGS=1 → reg_we high for 32 consecutive cycles; REG[k]=k for k=0..31; state then LOAD.
- Stream 6 words to addresses 0–5 (32'h00222000, 32'h04432800, 32'h10E60001, 32'h1D090001, 32'h190A0001, 32'h20000028) with ld_last on word 5 → 6 mem_we pulses with matching address/data; load_count=6; core_run rises.
- halt_pc=47, core reaches PC 47 at RUN cycle 9 → done=1, timeout=0, cycle_count=9, core_run=0.
- halt_pc unreachable, max_cycles=20 → done=1, timeout=1, cycle_count=20.
- halt_pc matched on the same cycle cycle_count hits max_cycles → timeout=0.
- rst_n pulsed low mid-LOAD after 3 words → all outputs 0 immediately; start then replays REG_INIT; ld_valid stalls with ld_ready=0 outside LOAD produce no mem_we.
